// File: rtl/xibus_pkg.sv
// +---------------------------------------------------------------------------+
// | xibus_pkg : shared types and constants for the XiBus master sequencer      |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

package xibus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    ADDR  = 3'd2,
    DATA  = 3'd3,
    RESP  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    RSP_OK          = 2'd0,
    RSP_ERR_STROBE  = 2'd1,
    RSP_ERR_TIMEOUT = 2'd2
  } resp_t;

  localparam logic [3:0]  WR_READ      = 4'b0000;
  localparam int unsigned ADDR_CYC_DEF = 1;
  localparam int unsigned TIMEOUT_DEF  = 64;

endpackage

`default_nettype wire

// File: rtl/xibus_timeout_cnt.sv
// +---------------------------------------------------------------------------+
// | xibus_timeout_cnt : clear/enable up-counter with terminal-count compare    |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module xibus_timeout_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + W'(1);
  end

  assign tc = (cnt == term);

endmodule

`default_nettype wire

// File: rtl/xibus_master_seq.sv
// +---------------------------------------------------------------------------+
// | xibus_master_seq : XiBus bus-cycle controller (AS#/DS#, RDY#, timeout)     |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module xibus_master_seq
  import xibus_pkg::*;
#(
  parameter int unsigned ADDR_CYC = ADDR_CYC_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
  parameter int unsigned TO_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack_o,
  output logic        cpu_err_o,
  output logic [31:0] cpu_rdata_o,
  output logic        enc_adrcy_o,
  output logic [3:0]  enc_write_o,
  output logic [31:0] enc_addr_o,
  output logic [31:0] enc_wdata_o,
  input  logic        enc_error_i,
  output logic        as_n_o,
  output logic        ds_n_o,
  output logic        ad_oe_o,
  input  logic [31:0] ad_i,
  input  logic        rdy_n_i
);

  localparam logic [TO_W-1:0] TO_TERM = TO_W'(TIMEOUT - 1);
  localparam logic [3:0]      AC_TERM = 4'(ADDR_CYC - 1);

  state_t state;
  state_t state_nxt;
  resp_t  resp;
  logic   addr_done;
  logic   to_hit;
  logic   is_read;

  assign is_read = (enc_write_o == WR_READ);

  xibus_timeout_cnt #(.W(4)) u_addr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != ADDR),
    .en    (state == ADDR),
    .term  (AC_TERM),
    .tc    (addr_done)
  );

  // Counts only stalled DATA cycles; the count shown in DATA cycle k is k-1.
  xibus_timeout_cnt #(.W(TO_W)) u_to_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != DATA),
    .en    ((state == DATA) && rdy_n_i),
    .term  (TO_TERM),
    .tc    (to_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cpu_req) state_nxt = SETUP;
      SETUP:   state_nxt = enc_error_i ? RESP : ADDR;
      ADDR:    if (addr_done) state_nxt = DATA;
      DATA:    if (!rdy_n_i || to_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_write_o <= '0;
      enc_addr_o  <= '0;
      enc_wdata_o <= '0;
      cpu_rdata_o <= '0;
      resp        <= RSP_OK;
    end else begin
      if (state == IDLE && cpu_req) begin
        enc_write_o <= cpu_write;
        enc_addr_o  <= cpu_addr;
        enc_wdata_o <= cpu_wdata;
      end
      if (state == SETUP)
        resp <= enc_error_i ? RSP_ERR_STROBE : RSP_OK;
      if (state == DATA) begin
        // RDY# takes priority over a simultaneous timeout.
        if (!rdy_n_i) begin
          resp <= RSP_OK;
          if (is_read)
            cpu_rdata_o <= ad_i;
        end else if (to_hit) begin
          resp <= RSP_ERR_TIMEOUT;
        end
      end
    end
  end

  always_comb begin
    as_n_o      = 1'b1;
    ds_n_o      = 1'b1;
    ad_oe_o     = 1'b0;
    enc_adrcy_o = 1'b0;
    cpu_ack_o   = 1'b0;
    cpu_err_o   = 1'b0;
    unique case (state)
      SETUP: begin
        enc_adrcy_o = 1'b1;
        ad_oe_o     = 1'b1;
      end
      ADDR: begin
        enc_adrcy_o = 1'b1;
        ad_oe_o     = 1'b1;
        as_n_o      = 1'b0;
      end
      DATA: begin
        ds_n_o  = 1'b0;
        ad_oe_o = !is_read;
      end
      RESP: begin
        cpu_ack_o = (resp == RSP_OK);
        cpu_err_o = (resp != RSP_OK);
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_xibus_master_seq.sv
// +---------------------------------------------------------------------------+
// | tb_xibus_master_seq : directed self-checking bench for xibus_master_seq    |
// | Rev 1.0                                                                    |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_xibus_master_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic [3:0]  cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic        cpu_err;
  logic [31:0] cpu_rdata;
  logic        enc_adrcy;
  logic [3:0]  enc_write;
  logic [31:0] enc_addr;
  logic [31:0] enc_wdata;
  logic        enc_error;
  logic        as_n;
  logic        ds_n;
  logic        ad_oe;
  logic [31:0] ad;
  logic        rdy_n;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Stand-in for the strobe encoder: contiguous aligned byte/half/word patterns are legal.
  function automatic logic strobe_illegal(input logic [3:0] w);
    case (w)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b0;
      default:                   return 1'b1;
    endcase
  endfunction

  assign enc_error = strobe_illegal(enc_write);

  xibus_master_seq #(
    .ADDR_CYC (1),
    .TIMEOUT  (8),
    .TO_W     (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_req     (cpu_req),
    .cpu_write   (cpu_write),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack_o   (cpu_ack),
    .cpu_err_o   (cpu_err),
    .cpu_rdata_o (cpu_rdata),
    .enc_adrcy_o (enc_adrcy),
    .enc_write_o (enc_write),
    .enc_addr_o  (enc_addr),
    .enc_wdata_o (enc_wdata),
    .enc_error_i (enc_error),
    .as_n_o      (as_n),
    .ds_n_o      (ds_n),
    .ad_oe_o     (ad_oe),
    .ad_i        (ad),
    .rdy_n_i     (rdy_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_write = 4'b0000;
    cpu_addr  = '0;
    cpu_wdata = '0;
    ad        = '0;
    rdy_n     = 1'b1;
    step();
    step();
    chk("rst_as_n",  as_n, 1);
    chk("rst_ds_n",  ds_n, 1);
    chk("rst_oe",    ad_oe, 0);
    chk("rst_adrcy", enc_adrcy, 0);
    chk("rst_ack",   cpu_ack, 0);
    chk("rst_err",   cpu_err, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_eaddr", enc_addr, 0);
    rst_n = 1'b1;
    step();

    // Read, zero-wait target
    cpu_req = 1'b1; cpu_write = 4'b0000; cpu_addr = 32'h0000_1004;
    step();
    chk("rd_setup_adrcy", enc_adrcy, 1);
    chk("rd_setup_oe",    ad_oe, 1);
    chk("rd_setup_as_n",  as_n, 1);
    chk("rd_latch_addr",  enc_addr, 32'h0000_1004);
    cpu_addr = 32'hFFFF_0000;
    step();
    chk("rd_addr_as_n",  as_n, 0);
    chk("rd_addr_ds_n",  ds_n, 1);
    rdy_n = 1'b0; ad = 32'hDEAD_BEEF;
    step();
    chk("rd_data_ds_n",  ds_n, 0);
    chk("rd_data_as_n",  as_n, 1);
    chk("rd_data_oe",    ad_oe, 0);
    chk("rd_data_adrcy", enc_adrcy, 0);
    chk("rd_hold_addr",  enc_addr, 32'h0000_1004);
    step();
    chk("rd_ack",   cpu_ack, 1);
    chk("rd_err",   cpu_err, 0);
    chk("rd_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("rd_resp_ds_n", ds_n, 1);
    cpu_req = 1'b0; rdy_n = 1'b1; ad = 32'h0;
    step();
    chk("rd_idle_ack",  cpu_ack, 0);
    chk("rd_idle_rdat", cpu_rdata, 32'hDEAD_BEEF);

    // Write with three wait states
    cpu_req = 1'b1; cpu_write = 4'b1111; cpu_addr = 32'h0000_2000; cpu_wdata = 32'h1234_5678;
    step();
    chk("wr_latch_wdata", enc_wdata, 32'h1234_5678);
    step();
    chk("wr_addr_as_n", as_n, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("wr_data_ds_n", ds_n, 0);
      chk("wr_data_oe",   ad_oe, 1);
      chk("wr_data_ack",  cpu_ack, 0);
      if (k == 4) rdy_n = 1'b0;
    end
    step();
    chk("wr_ack",   cpu_ack, 1);
    chk("wr_err",   cpu_err, 0);
    chk("wr_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("wr_resp_oe", ad_oe, 0);
    cpu_req = 1'b0; rdy_n = 1'b1;
    step();

    // Illegal strobes rejected before any strobe
    cpu_req = 1'b1; cpu_write = 4'b0101; cpu_addr = 32'h0000_3000;
    step();
    chk("ill_setup_as_n", as_n, 1);
    chk("ill_setup_ds_n", ds_n, 1);
    step();
    chk("ill_err",  cpu_err, 1);
    chk("ill_ack",  cpu_ack, 0);
    chk("ill_as_n", as_n, 1);
    chk("ill_ds_n", ds_n, 1);
    cpu_req = 1'b0;
    step();
    chk("ill_idle_err",   cpu_err, 0);
    chk("ill_idle_adrcy", enc_adrcy, 0);
    chk("ill_idle_as_n",  as_n, 1);

    // Timeout after 8 stalled DATA cycles
    cpu_req = 1'b1; cpu_write = 4'b0000; cpu_addr = 32'h0000_4000; ad = 32'hBAD0_BAD0;
    step();
    step();
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("to_data_ds_n", ds_n, 0);
      chk("to_data_err",  cpu_err, 0);
    end
    step();
    chk("to_err",   cpu_err, 1);
    chk("to_ack",   cpu_ack, 0);
    chk("to_rdata", cpu_rdata, 32'hDEAD_BEEF);
    cpu_req = 1'b0;
    step();

    // RDY# on the 8th DATA cycle wins over timeout
    cpu_req = 1'b1; cpu_write = 4'b0000; cpu_addr = 32'h0000_4004;
    step();
    step();
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("rw_data_ds_n", ds_n, 0);
      if (k == 8) begin rdy_n = 1'b0; ad = 32'hCAFE_F00D; end
    end
    step();
    chk("rw_ack",   cpu_ack, 1);
    chk("rw_err",   cpu_err, 0);
    chk("rw_rdata", cpu_rdata, 32'hCAFE_F00D);
    cpu_req = 1'b0; rdy_n = 1'b1;
    step();

    // Asynchronous reset during a write DATA phase
    cpu_req = 1'b1; cpu_write = 4'b0011; cpu_addr = 32'h0000_5000; cpu_wdata = 32'hA5A5_5A5A;
    step();
    step();
    step();
    chk("ar_data_ds_n", ds_n, 0);
    chk("ar_data_oe",   ad_oe, 1);
    rst_n = 1'b0; cpu_req = 1'b0;
    #1;
    chk("ar_ds_n", ds_n, 1);
    chk("ar_oe",   ad_oe, 0);
    chk("ar_as_n", as_n, 1);
    chk("ar_ack",  cpu_ack, 0);
    chk("ar_err",  cpu_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar_post_ack",   cpu_ack, 0);
    chk("ar_post_err",   cpu_err, 0);
    chk("ar_post_rdata", cpu_rdata, 0);
    cpu_req = 1'b1; cpu_write = 4'b0000; cpu_addr = 32'h0000_6000;
    step();
    step();
    rdy_n = 1'b0; ad = 32'h55AA_1234;
    step();
    step();
    chk("ar_new_ack",   cpu_ack, 1);
    chk("ar_new_rdata", cpu_rdata, 32'h55AA_1234);

    // Back-to-back with cpu_req held high: one IDLE cycle, then new latch
    cpu_addr = 32'h0000_7000; ad = 32'h0BAD_CAFE;
    step();
    chk("bb_idle_adrcy", enc_adrcy, 0);
    chk("bb_idle_ack",   cpu_ack, 0);
    chk("bb_idle_addr",  enc_addr, 32'h0000_6000);
    step();
    chk("bb_setup_adrcy", enc_adrcy, 1);
    chk("bb_setup_addr",  enc_addr, 32'h0000_7000);
    step();
    chk("bb_addr_as_n", as_n, 0);
    step();
    chk("bb_data_ds_n", ds_n, 0);
    step();
    chk("bb_ack",   cpu_ack, 1);
    chk("bb_rdata", cpu_rdata, 32'h0BAD_CAFE);
    cpu_req = 1'b0; rdy_n = 1'b1;
    step();
    step();
    chk("bb_final_adrcy", enc_adrcy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/xibus_master_seq.md
Name: xibus_master_seq

Overview:
Sequential bus-cycle controller directly upstream of the XiBus write-strobe encoder. It accepts one CPU request at a time, latches it, and drives the encoder's inputs (adrcy, write strobes, address, write data). It sequences the multiplexed address and data phases with AS#/DS# strobes, waits for target RDY#, and enforces a timeout. It returns read data and ack/error to the CPU, and consumes the encoder's error flag to abort illegal strobe patterns before any strobe is driven.

Parameters:
ADDR_CYC, 1, number of cycles AS# is held low in the address phase (1..15)
TIMEOUT, 64, max DATA-phase cycles waiting for RDY# before abort (2..65535)
TO_W, 16, width of the timeout counter; must satisfy 2**TO_W > TIMEOUT

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cpu_req  input  1  request; held high until cpu_ack_o or cpu_err_o
cpu_write  input  4  byte write strobes; 0000 = read word
cpu_addr  input  32  byte address
cpu_wdata  input  32  write data
cpu_ack_o  output  1  one-cycle completion pulse
cpu_err_o  output  1  one-cycle error pulse (illegal strobes or timeout)
cpu_rdata_o  output  32  read data, valid with cpu_ack_o and held afterwards
enc_adrcy_o  output  1  to encoder adrcy: 1 = address phase on AD
enc_write_o  output  4  latched cpu_write to encoder
enc_addr_o  output  32  latched cpu_addr to encoder
enc_wdata_o  output  32  latched cpu_wdata to encoder
enc_error_i  input  1  encoder error flag for the latched strobes
as_n_o  output  1  address strobe, active low
ds_n_o  output  1  data strobe, active low
ad_oe_o  output  1  AD bus output enable, master drives when 1
ad_i  input  32  AD bus input (read data)
rdy_n_i  input  1  target ready, active low, sampled on rising clk

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state IDLE; as_n_o=1, ds_n_o=1, ad_oe_o=0, enc_adrcy_o=0; cpu_ack_o=0, cpu_err_o=0; cpu_rdata_o=0; enc_write/addr/wdata=0.
- Reset mid-cycle: strobes deassert and OE drops immediately (async). No ack or error is issued.
- All outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.
- States: IDLE, SETUP, ADDR, DATA, RESP.
- IDLE: all strobes high, ad_oe_o=0. On cpu_req=1: latch write/addr/wdata into enc_* registers, go to SETUP.
- SETUP (1 cycle): enc_adrcy_o=1, ad_oe_o=1, strobes high (address setup).
  - If enc_error_i=1: go to RESP with err flag set; no strobe is ever asserted.
  - Else go to ADDR.
- ADDR (ADDR_CYC cycles, counted): enc_adrcy_o=1, ad_oe_o=1, as_n_o=0. Then go to DATA.
- DATA:
  - enc_adrcy_o=0, as_n_o=1, ds_n_o=0.
  - ad_oe_o=1 if enc_write_o!=0, else 0.
  - The timeout counter clears on entry and increments each cycle rdy_n_i=1.
  - rdy_n_i=0 sampled: if read, capture ad_i into cpu_rdata_o; go to RESP (ok).
  - Counter reaches TIMEOUT-1 with rdy_n_i still 1: go to RESP (err).
  - If RDY# and timeout occur in the same cycle, RDY# wins.
- RESP (1 cycle): strobes high, ad_oe_o=0 (bus turnaround). Exactly one of cpu_ack_o or cpu_err_o is 1. Then go to IDLE.
- cpu_req is ignored in RESP, so back-to-back requests have minimum spacing of one IDLE cycle.
- cpu_rdata_o updates only on a successful read. Writes and errors leave it unchanged.
- Latency (ADDR_CYC=1, zero-wait target), with the request sampled at edge 0:
  - SETUP is cycle 1, ADDR cycle 2, DATA cycle 3, RDY# sampled at edge 4.
  - cpu_ack_o is high during cycle 4 (4 cycles after the request is sampled).
  - Each wait state adds 1 cycle.
- Encoder error path: cpu_err_o is high in cycle 2 (SETUP→RESP).
- cpu_req or cpu_* changing after latch has no effect until the next IDLE.

Decomposition:
- Package xibus_pkg:
  - state enum (IDLE/SETUP/ADDR/DATA/RESP).
  - WR_READ=4'b0000 constant.
  - Default ADDR_CYC and TIMEOUT constants.
  - Response code enum (OK/ERR_STROBE/ERR_TIMEOUT), used for debug visibility.
- One sub-module: xibus_timeout_cnt (clear/enable/terminal-count counter, TO_W wide). It is reused for the ADDR_CYC count via a separate instance.

Test Plan:
- Read, cpu_write=0000, addr=0x0000_1004, RDY# low on first DATA cycle, ad_i=0xDEAD_BEEF -> as_n low cycle 2, ds_n low cycle 3, ad_oe 0 in DATA, cpu_ack_o cycle 4, cpu_rdata_o=0xDEAD_BEEF.
- Write, cpu_write=1111, wdata=0x1234_5678, RDY# after 3 wait states -> ad_oe 1 through DATA, ds_n low 4 cycles, ack in cycle 7, cpu_rdata_o unchanged.
- Illegal strobes 0101 (encoder error_o=1) -> as_n_o and ds_n_o never low, cpu_err_o pulse in cycle 2, back to IDLE in cycle 3.
- Timeout, TIMEOUT=8, rdy_n_i held 1 -> cpu_err_o after 8 DATA cycles. Also: RDY# asserted on the 8th cycle -> ack, no error.
- rst_n pulled low during DATA -> ds_n_o=1 and ad_oe_o=0 immediately, no ack/err. After release, a new request completes normally.
- Back-to-back requests with cpu_req held high -> second SETUP starts exactly one IDLE cycle after RESP, with correct latched address.
